// File: rtl/bttn_pkg.sv
// rtl/bttn_pkg.sv - shared state type and default timing constants for button handling
package bttn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNTING,
    ST_LATCHED
  } bttn_state_t;

  localparam int CYCLES_PER_TICK_DEF = 50_000_000;
  localparam int HOLD_TICKS_DEF      = 5;

endpackage

// File: rtl/bttn_sync2.sv
// rtl/bttn_sync2.sv - two-flop synchronizer for an asynchronous button level
module bttn_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bttn_test.sv
// rtl/bttn_test.sv - long-press detector toggling the test-mode flag once per qualifying press
module bttn_test
  import bttn_pkg::*;
#(
  parameter int CYCLES_PER_TICK = CYCLES_PER_TICK_DEF,
  parameter int HOLD_TICKS      = HOLD_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic botonTest,
  output logic btnTest
);

  localparam int PRE_W  = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam int TICK_W = $clog2(HOLD_TICKS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_TICK - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(HOLD_TICKS - 1);

  bttn_state_t       r_state, w_state_nxt;
  logic [PRE_W-1:0]  r_pre, w_pre_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic              r_btn, w_btn_nxt;
  logic              w_btn_s;
  logic              w_pre_wrap;

  bttn_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (botonTest),
    .o_q   (w_btn_s)
  );

  assign w_pre_wrap = (r_pre == PRE_LAST);

  // IDLE shares the counting path: its counters are zero, so the first pressed cycle advances them
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = '0;
    w_tick_nxt  = '0;
    w_btn_nxt   = r_btn;
    case (r_state)
      ST_IDLE, ST_COUNTING: begin
        if (w_btn_s) begin
          if (w_pre_wrap && (r_tick == TICK_LAST)) begin
            w_btn_nxt   = ~r_btn;
            w_state_nxt = ST_LATCHED;
          end else begin
            w_state_nxt = ST_COUNTING;
            w_pre_nxt   = w_pre_wrap ? '0 : r_pre + 1'b1;
            w_tick_nxt  = r_tick + TICK_W'(w_pre_wrap);
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LATCHED: begin
        if (!w_btn_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_tick  <= '0;
      r_btn   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_tick  <= w_tick_nxt;
      r_btn   <= w_btn_nxt;
    end
  end

  assign btnTest = r_btn;

endmodule

// File: tb/tb_bttn_test.sv
// tb/tb_bttn_test.sv - randomized scoreboard bench for bttn_test against a press-run-length model
module tb_bttn_test;

  logic clk = 1'b0;
  logic rst;
  logic botonTest;
  logic btn_a;
  logic btn_b;

  always #5 clk = ~clk;

  bttn_test #(.CYCLES_PER_TICK(1), .HOLD_TICKS(5)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .botonTest (botonTest),
    .btnTest   (btn_a)
  );

  bttn_test #(.CYCLES_PER_TICK(3), .HOLD_TICKS(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .botonTest (botonTest),
    .btnTest   (btn_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit q_a[$];
  bit q_b[$];

  // Model: a toggle happens when the synchronized press run reaches exactly HOLD*CPT cycles
  bit s1[2];
  bit s2[2];
  int run[2];
  bit expv[2];
  int nlen[2] = '{5, 6};

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        s1[i] = 1'b0;
        s2[i] = 1'b0;
        run[i] = 0;
        expv[i] = 1'b0;
      end else begin
        if (s2[i]) begin
          run[i]++;
          if (run[i] == nlen[i]) expv[i] = ~expv[i];
        end else begin
          run[i] = 0;
        end
        s2[i] = s1[i];
        s1[i] = botonTest;
      end
    end
    q_a.push_back(expv[0]);
    q_b.push_back(expv[1]);
  endtask

  task automatic cyc(input bit raw);
    @(negedge clk);
    botonTest = raw;
    model_step();
  endtask

  task automatic hold(input bit raw, input int n);
    repeat (n) cyc(raw);
  endtask

  task automatic release_rst(input bit raw);
    @(negedge clk);
    rst = 1'b1;
    botonTest = raw;
    model_step();
  endtask

  task automatic async_reset(input int n_cycles, input bit raw_after);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_a", btn_a, 1'b0);
    check("async_rst_b", btn_b, 1'b0);
    model_step();
    hold(botonTest, n_cycles - 1);
    release_rst(raw_after);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() != 0) begin
        check("btn_a", btn_a, q_a.pop_front());
        check("btn_b", btn_b, q_b.pop_front());
      end
    end
  end

  initial begin
    bit v;
    rst = 1'b0;
    botonTest = 1'b1;
    #3;
    check("reset_a", btn_a, 1'b0);
    check("reset_b", btn_b, 1'b0);
    hold(1'b1, 1);
    release_rst(1'b0);
    hold(1'b0, 3);

    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 3);

    hold(1'b1, 11);
    hold(1'b0, 3);
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 1);
      hold(1'b0, 1);
    end
    hold(1'b0, 2);
    hold(1'b1, 11);
    hold(1'b0, 3);

    hold(1'b1, 6);
    hold(1'b0, 4);
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 8);
    hold(1'b0, 4);
    hold(1'b1, 7);
    hold(1'b0, 4);

    hold(1'b1, 4);
    async_reset(2, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 3);

    v = 1'b0;
    for (int k = 0; k < 80; k++) begin
      v = ~v;
      hold(v, $urandom_range(1, 14));
      if ($urandom_range(0, 9) == 0) async_reset(2, 1'($urandom_range(0, 1)));
    end
    hold(1'b0, 4);

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_a.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
